// File: rtl/int_timer_pkg.sv
// Shared constants for the programmable interval timer: register map,
// CTRL/STATUS bit positions and the IRQ handshake state encoding.
package int_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PS_LSB = 8;

  localparam int STAT_PEND = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_EXP  = 2;

  // Interrupt-handler line driven by this timer (irq1 / ack1).
  localparam int TIMER_IRQ_LINE = 1;

  typedef enum logic [1:0] {
    H_IDLE    = 2'd0,
    H_PULSE   = 2'd1,
    H_WAIT_LO = 2'd2,
    H_WAIT_HI = 2'd3
  } hs_state_t;

endpackage

// File: rtl/int_timer_prescaler.sv
// Prescaler: counts 0..ps while enabled and flags a tick on the terminal
// count; clr restarts the count from zero.
module timer_prescaler #(
  parameter int PS_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [PS_W-1:0] ps,
  output logic            tick
);

  logic [PS_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == ps);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/int_timer.sv
// Interval timer with a 4-register I/O window; each accepted expiry raises a
// one-cycle irq and then follows the handler's ack low/high handshake.
module int_timer
  import int_timer_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               PS_W         = 8,
  parameter logic [WIDTH-1:0] RESET_RELOAD = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       io_addr,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [WIDTH-1:0] io_din,
  output logic [WIDTH-1:0] io_dout,
  output logic             irq,
  input  logic             ack,
  output logic             tick_out
);

  logic             en_reg, auto_reg, ie_reg;
  logic [PS_W-1:0]  ps_reg;
  logic [WIDTH-1:0] reload_reg, count_reg, dout_reg;
  logic             ovr_reg, exp_reg, irq_reg;
  hs_state_t        state_reg, state_next;

  logic wr_ctrl, wr_reload, wr_count, wr_status;
  logic en_rise, tick, tick_eff, expiry;
  logic [WIDTH-1:0] ctrl_rd, status_rd, rd_mux;
  logic unused_din;

  assign wr_ctrl   = io_wr && (io_addr == REG_CTRL);
  assign wr_reload = io_wr && (io_addr == REG_RELOAD);
  assign wr_count  = io_wr && (io_addr == REG_COUNT);
  assign wr_status = io_wr && (io_addr == REG_STATUS);

  assign en_rise  = wr_ctrl && io_din[CTRL_EN] && !en_reg;
  // A direct COUNT write swallows any tick landing on the same edge.
  assign tick_eff = tick && !wr_count;
  assign expiry   = tick_eff && (count_reg == '0);

  assign unused_din = ^io_din[CTRL_PS_LSB-1:CTRL_IE+1];

  timer_prescaler #(.PS_W(PS_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en_reg),
    .clr  (en_rise),
    .ps   (ps_reg),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg   <= 1'b0;
      auto_reg <= 1'b0;
      ie_reg   <= 1'b0;
      ps_reg   <= '0;
    end else if (wr_ctrl) begin
      en_reg   <= io_din[CTRL_EN];
      auto_reg <= io_din[CTRL_AUTO];
      ie_reg   <= io_din[CTRL_IE];
      ps_reg   <= io_din[CTRL_PS_LSB +: PS_W];
    end else if (expiry && !auto_reg) begin
      en_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_reg <= RESET_RELOAD;
      count_reg  <= '0;
    end else begin
      if (wr_reload) reload_reg <= io_din;
      if (wr_count) begin
        count_reg <= io_din;
      end else if (en_rise) begin
        count_reg <= reload_reg;
      end else if (tick_eff) begin
        if (count_reg != '0)  count_reg <= count_reg - 1'b1;
        else if (auto_reg)    count_reg <= reload_reg;
      end
    end
  end

  // Sticky flags: a set event on the same edge beats the write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_reg <= 1'b0;
      exp_reg <= 1'b0;
    end else begin
      ovr_reg <= (ovr_reg && !(wr_status && io_din[STAT_OVR]))
                 || (expiry && (state_reg != H_IDLE));
      exp_reg <= (exp_reg && !(wr_status && io_din[STAT_EXP])) || expiry;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      H_IDLE:    if (expiry && ie_reg) state_next = H_PULSE;
      H_PULSE:   state_next = H_WAIT_LO;
      H_WAIT_LO: if (!ack) state_next = H_WAIT_HI;
      H_WAIT_HI: if (ack)  state_next = H_IDLE;
      default:   state_next = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= H_IDLE;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      irq_reg   <= (state_next == H_PULSE);
    end
  end

  always_comb begin
    ctrl_rd                        = '0;
    ctrl_rd[CTRL_EN]               = en_reg;
    ctrl_rd[CTRL_AUTO]             = auto_reg;
    ctrl_rd[CTRL_IE]               = ie_reg;
    ctrl_rd[CTRL_PS_LSB +: PS_W]   = ps_reg;
    status_rd                      = '0;
    status_rd[STAT_PEND]           = (state_reg != H_IDLE);
    status_rd[STAT_OVR]            = ovr_reg;
    status_rd[STAT_EXP]            = exp_reg;
    case (io_addr)
      REG_CTRL:   rd_mux = ctrl_rd;
      REG_RELOAD: rd_mux = reload_reg;
      REG_COUNT:  rd_mux = count_reg;
      default:    rd_mux = status_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        dout_reg <= '0;
    else if (io_rd) dout_reg <= rd_mux;
  end

  assign io_dout  = dout_reg;
  assign irq      = irq_reg;
  assign tick_out = tick;

endmodule

// File: tb/tb_int_timer.sv
// Bench for int_timer: table-driven register accesses, scoreboard queues for
// read data and irq pulse edges, and hand-written handshake/reset sequences.
module tb_int_timer;
  import int_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  io_addr = 2'd0;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [15:0] io_din = 16'h0;
  logic [15:0] io_dout;
  logic        irq;
  logic        ack;
  logic        tick_out;

  logic        handler_on = 1'b1;
  logic        man_ack = 1'b1;
  logic        h_ack = 1'b1;
  int          hcnt = 0;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        rd_flag = 1'b0;
  logic        prev_irq = 1'b0;
  logic [15:0] rd_q[$];
  int          irq_q[$];
  int          e;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t reset_tab[4];

  assign ack = handler_on ? h_ack : man_ack;

  always #5 clk = ~clk;

  int_timer dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .irq      (irq),
    .ack      (ack),
    .tick_out (tick_out)
  );

  // Handler model: ack drops the cycle after irq and returns 5 cycles later.
  always @(posedge clk) begin
    if (irq === 1'b1) begin
      h_ack <= 1'b0;
      hcnt  <= 5;
    end else if (hcnt != 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) h_ack <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    if (rd_flag) begin
      if (rd_q.size() == 0) chk("read_queue", 32'd1, 32'd0);
      else chk("read_data", {16'h0, io_dout}, {16'h0, rd_q.pop_front()});
    end
    if (irq !== 1'b0) begin
      chk("irq_width", {31'h0, prev_irq}, 32'd0);
      if (irq_q.size() == 0) chk("irq_unexpected", cyc, 32'hFFFFFFFF);
      else chk("irq_edge", cyc, irq_q.pop_front());
    end
    prev_irq = (irq === 1'b1);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    rd_flag = io_rd;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    io_addr = a; io_din = d; io_wr = 1'b1;
    step();
    io_wr = 1'b0;
    $display("edge %0d: wr addr %0d data %h", cyc, a, d);
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [15:0] expv);
    io_addr = a; io_rd = 1'b1;
    rd_q.push_back(expv);
    step();
    io_rd = 1'b0;
    $display("edge %0d: rd addr %0d expect %h", cyc, a, expv);
  endtask

  task automatic run_tab();
    for (int i = 0; i < 4; i++) begin
      if (reset_tab[i].wr) bus_wr(reset_tab[i].addr, reset_tab[i].data);
      else bus_rd(reset_tab[i].addr, reset_tab[i].exp);
    end
    step();
  endtask

  initial begin
    reset_tab[0] = '{1'b0, REG_CTRL,   16'h0, 16'h0000};
    reset_tab[1] = '{1'b0, REG_RELOAD, 16'h0, 16'hFFFF};
    reset_tab[2] = '{1'b0, REG_COUNT,  16'h0, 16'h0000};
    reset_tab[3] = '{1'b0, REG_STATUS, 16'h0, 16'h0000};

    repeat (3) step();
    rst = 1'b0;
    chk("dout_reset", {16'h0, io_dout}, 32'h0);
    run_tab();

    // Auto-reload, PS=0, period 8, handler services each irq.
    bus_wr(REG_RELOAD, 16'd7);
    bus_wr(REG_CTRL, 16'h0007);
    e = cyc;
    irq_q.push_back(e + 8);
    irq_q.push_back(e + 16);
    irq_q.push_back(e + 24);
    wait_until(e + 26);
    bus_wr(REG_CTRL, 16'h0000);
    repeat (10) step();
    chk("auto_irq_count", irq_q.size(), 0);
    bus_rd(REG_STATUS, 16'h0004);
    bus_wr(REG_STATUS, 16'h0006);
    bus_rd(REG_STATUS, 16'h0000);

    // One-shot, PS=2, RELOAD=1: single expiry six cycles after enable.
    bus_wr(REG_RELOAD, 16'd1);
    bus_wr(REG_CTRL, 16'h0205);
    e = cyc;
    irq_q.push_back(e + 6);
    wait_until(e + 14);
    bus_rd(REG_CTRL, 16'h0204);
    bus_rd(REG_COUNT, 16'h0000);
    bus_rd(REG_STATUS, 16'h0004);
    bus_wr(REG_STATUS, 16'h0004);
    step();
    chk("oneshot_irq_count", irq_q.size(), 0);

    // Handler never services: later expiries become overruns.
    handler_on = 1'b0;
    man_ack = 1'b1;
    bus_wr(REG_CTRL, 16'h0007);
    e = cyc;
    irq_q.push_back(e + 2);
    wait_until(e + 5);
    bus_rd(REG_STATUS, 16'h0007);
    bus_wr(REG_CTRL, 16'h0000);
    bus_wr(REG_STATUS, 16'h0002);
    bus_rd(REG_STATUS, 16'h0005);
    man_ack = 1'b0;
    step();
    man_ack = 1'b1;
    repeat (2) step();
    bus_rd(REG_STATUS, 16'h0004);
    bus_wr(REG_STATUS, 16'h0006);
    bus_rd(REG_STATUS, 16'h0000);
    handler_on = 1'b1;

    // COUNT write on the tick that would expire COUNT=0: write wins.
    bus_wr(REG_RELOAD, 16'd3);
    bus_wr(REG_CTRL, 16'h0007);
    e = cyc;
    wait_until(e + 3);
    bus_wr(REG_COUNT, 16'd5);
    bus_rd(REG_COUNT, 16'd5);
    bus_rd(REG_COUNT, 16'd4);
    irq_q.push_back(e + 10);
    wait_until(e + 12);
    bus_wr(REG_CTRL, 16'h0000);
    repeat (10) step();
    chk("cntwr_irq_count", irq_q.size(), 0);

    // Reset while in H_WAIT_HI with COUNT=2.
    handler_on = 1'b0;
    man_ack = 1'b1;
    bus_wr(REG_RELOAD, 16'd7);
    bus_wr(REG_CTRL, 16'h0007);
    e = cyc;
    irq_q.push_back(e + 8);
    wait_until(e + 9);
    man_ack = 1'b0;
    wait_until(e + 11);
    bus_rd(REG_STATUS, 16'h0005);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    man_ack = 1'b1;
    chk("irq_after_rst", {31'h0, irq}, 32'd0);
    chk("dout_after_rst", {16'h0, io_dout}, 32'h0);
    handler_on = 1'b1;
    run_tab();

    // Fresh enable after reset gives a normal first irq.
    bus_wr(REG_RELOAD, 16'd3);
    bus_wr(REG_CTRL, 16'h0007);
    e = cyc;
    irq_q.push_back(e + 4);
    wait_until(e + 6);
    bus_wr(REG_CTRL, 16'h0000);
    repeat (10) step();
    chk("post_rst_irq_count", irq_q.size(), 0);
    chk("read_q_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
